// File: rtl/uart_rx.sv
// UART receiver: oversampled start detection, 5-9 data bits LSB-first, optional even parity, 1-2 stop bits.
// Optional build macro UART_RX_MAJORITY_VOTE_EN enables 2-of-3 majority sampling around each sample point.
module uart_rx #(
  parameter int unsigned OVERSAMPLE = 16
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [6:0] i_config,
  input  logic       i_sample_tick,
  input  logic       i_rx,
  output logic [8:0] o_rx_parallel,
  output logic       o_rx_valid,
  output logic       o_parity_error,
  output logic       o_frame_error,
  output logic       o_busy
);

  localparam int unsigned CNT_W = $clog2(OVERSAMPLE);
  localparam int unsigned IDX_W = 4;
  localparam int unsigned DAT_W = 9;
  localparam int unsigned ST_W  = 5;

  localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);

  localparam logic [ST_W-1:0] S_IDLE   = 5'b00001;
  localparam logic [ST_W-1:0] S_START  = 5'b00010;
  localparam logic [ST_W-1:0] S_DATA   = 5'b00100;
  localparam logic [ST_W-1:0] S_PARITY = 5'b01000;
  localparam logic [ST_W-1:0] S_STOP   = 5'b10000;

  logic rx_meta_q, rx_s_q, rx_prev_q;

  logic [ST_W-1:0]  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [DAT_W-1:0] shift_q, shift_d;
  logic [IDX_W-1:0] ws_q, ws_d;
  logic             pen_q, pen_d;
  logic             stop2_q, stop2_d;
  logic             perr_acc_q, perr_acc_d;
  logic             ferr_acc_q, ferr_acc_d;
  logic [DAT_W-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             perr_q, perr_d;
  logic             ferr_q, ferr_d;
  logic             busy_q, busy_d;

  logic             sample_c;
  logic [DAT_W-1:0] masked_c;

  // Two-flop synchronizer plus one stage for falling-edge detection; idle level is 1.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= i_rx;
      rx_s_q    <= rx_meta_q;
      rx_prev_q <= rx_s_q;
    end
  end

`ifdef UART_RX_MAJORITY_VOTE_EN
  logic [1:0] hist_q;

  // Line history on the two ticks preceding the current one.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      hist_q <= 2'b11;
    end else if (i_sample_tick) begin
      hist_q <= {hist_q[0], rx_s_q};
    end
  end

  assign sample_c = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s_q) | (hist_q[0] & rx_s_q);
`else
  assign sample_c = rx_s_q;
`endif

  function automatic logic [IDX_W-1:0] clamp_ws(input logic [IDX_W-1:0] w);
    if (w < 4'd5) return 4'd5;
    if (w > 4'd9) return 4'd9;
    return w;
  endfunction

  // Received word with bits at or above the word size forced to 0.
  always_comb begin
    masked_c = '0;
    for (int i = 0; i < DAT_W; i++) begin
      masked_c[i] = shift_q[i] & (IDX_W'(i) < ws_q);
    end
  end

  // Next-state and datapath logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    shift_d    = shift_q;
    ws_d       = ws_q;
    pen_d      = pen_q;
    stop2_d    = stop2_q;
    perr_acc_d = perr_acc_q;
    ferr_acc_d = ferr_acc_q;
    data_d     = data_q;
    valid_d    = 1'b0;
    perr_d     = perr_q;
    ferr_d     = ferr_q;

    case (state_q)
      S_IDLE: begin
        if (i_config[0]) begin
          ws_d    = clamp_ws(i_config[4:1]);
          pen_d   = i_config[5];
          stop2_d = i_config[6];
        end
        if (rx_prev_q && !rx_s_q) begin
          state_d = S_START;
          cnt_d   = '0;
        end
      end

      S_START: begin
        if (i_sample_tick) begin
          if (cnt_q == CNT_MID) begin
            cnt_d = '0;
            if (!sample_c) begin
              idx_d      = '0;
              shift_d    = '0;
              perr_acc_d = 1'b0;
              ferr_acc_d = 1'b0;
              state_d    = S_DATA;
            end else begin
              state_d = S_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_DATA: begin
        if (i_sample_tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d          = '0;
            shift_d[idx_q] = sample_c;
            if (idx_q == ws_q - 4'd1) begin
              idx_d   = {3'b000, stop2_q};
              state_d = pen_q ? S_PARITY : S_STOP;
            end else begin
              idx_d = idx_q + 4'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_PARITY: begin
        if (i_sample_tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d      = '0;
            perr_acc_d = sample_c ^ (^shift_q);
            state_d    = S_STOP;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_STOP: begin
        if (i_sample_tick) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d      = '0;
            ferr_acc_d = ferr_acc_q | ~sample_c;
            if (idx_q == 4'd0) begin
              data_d  = masked_c;
              perr_d  = pen_q & perr_acc_q;
              ferr_d  = ferr_acc_q | ~sample_c;
              valid_d = 1'b1;
              state_d = S_IDLE;
            end else begin
              idx_d = idx_q - 4'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      idx_q      <= '0;
      shift_q    <= '0;
      ws_q       <= 4'd8;
      pen_q      <= 1'b1;
      stop2_q    <= 1'b0;
      perr_acc_q <= 1'b0;
      ferr_acc_q <= 1'b0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      perr_q     <= 1'b0;
      ferr_q     <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      shift_q    <= shift_d;
      ws_q       <= ws_d;
      pen_q      <= pen_d;
      stop2_q    <= stop2_d;
      perr_acc_q <= perr_acc_d;
      ferr_acc_q <= ferr_acc_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      perr_q     <= perr_d;
      ferr_q     <= ferr_d;
      busy_q     <= busy_d;
    end
  end

  assign o_rx_parallel  = data_q;
  assign o_rx_valid     = valid_q;
  assign o_parity_error = perr_q;
  assign o_frame_error  = ferr_q;
  assign o_busy         = busy_q;

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial-to-parallel UART receiver, the receive-side counterpart of the transmitter. It uses the same 7-bit configuration word and the same defaults: 8 data bits, parity enabled, 1 stop bit. It samples the asynchronous serial line using an external oversampling strobe, assembles LSB-first words of 5–9 bits, checks parity and stop bits, and presents each word on a parallel bus with a one-cycle valid pulse.

## Interface
- `OVERSAMPLE`, default 16: number of `i_sample_tick` pulses per bit period; must be even and ≥ 8.
- `i_clk` input 1: system clock; all logic is on its rising edge.
- `i_rst_n` input 1: reset, synchronous, active-low.
- `i_config` input 7: configuration word.
  - [0] store config.
  - [4:1] word size, clamped to [5,9].
  - [5] parity enable.
  - [6] stop bits: 0 = one stop bit, 1 = two stop bits.
- `i_sample_tick` input 1: one-`i_clk` strobe at `OVERSAMPLE` × baud rate.
- `i_rx` input 1: asynchronous serial line; idle level is 1.
- `o_rx_parallel` output 9: received word, zero-extended above the word size.
- `o_rx_valid` output 1: one-cycle pulse when a frame completes.
- `o_parity_error` output 1: parity mismatch on the last frame.
- `o_frame_error` output 1: a stop bit sampled 0 on the last frame.
- `o_busy` output 1: high while a frame is in progress (any state other than IDLE).

## Operation
- `i_rx` passes through a 2-flop synchronizer; both flops reset to 1. All logic below uses the synchronized value `rx_s`.
- Tick counter `cnt` has width clog2(`OVERSAMPLE`) and advances only on `i_sample_tick`.
- Bit index `idx` is 4 bits.
- States: IDLE, START, DATA, PARITY, STOP. Encoding is one-hot.
- **IDLE**
  - If `i_config[0]` is high, latch the configuration:
    - parity enable = `i_config[5]`;
    - stop bits = `i_config[6]`;
    - word size = `i_config[4:1]` clamped: values < 5 become 5, values > 9 become 9.
  - Configuration is ignored in every other state.
  - A 1→0 transition of `rx_s` moves to START with `cnt` = 0.
- **START**
  - At `cnt` == `OVERSAMPLE`/2−1 on a tick, sample the line.
  - Sample = 0: clear `cnt` and `idx`, clear the shift register, go to DATA.
  - Sample = 1: false start; return to IDLE with no outputs changed.
- **DATA**
  - At `cnt` == `OVERSAMPLE`−1 on a tick, store the sample in `shift[idx]` and increment `idx`.
  - After bit word_size−1: go to PARITY if parity is enabled, otherwise to STOP. Set `idx` to the number of stop bits minus 1.
- **PARITY**
  - Sample one bit at the same point as in DATA.
  - Parity error = sample XOR (XOR of the received data bits); this is even parity.
- **STOP**
  - Sample each stop bit at the same point as in DATA; any 0 sets the frame error.
  - On the final stop bit:
    - load `o_rx_parallel` with the shift register, bits at or above the word size forced to 0;
    - load `o_parity_error` (forced to 0 when parity is disabled) and `o_frame_error`;
    - pulse `o_rx_valid`;
    - go to IDLE.
- Outputs hold their values until the next completed frame. A false start or a reset discards the partial frame.
- Re-entry to IDLE is immediate, so back-to-back frames are accepted. The next start edge is detectable in the cycle after returning to IDLE.

## Timing
- Reset values:
  - all outputs 0;
  - state IDLE;
  - configuration 8 data bits, parity enabled, 1 stop bit;
  - `cnt` and `idx` 0.
- Reset asserted mid-frame:
  - the frame is aborted;
  - the state returns to IDLE on the next `i_clk` edge;
  - no `o_rx_valid` is produced.
- Start detection: synchronizer latency 2 cycles, plus 1 cycle for edge detection.
- `o_rx_valid` is high exactly one `i_clk` cycle, in the cycle after the tick that samples the final stop bit. Data and error outputs are valid in that same cycle.
- A tick that arrives while the state changes belongs to the new state.
- `i_config[0]` in the same cycle as a start edge: the configuration is latched and the frame is received using the new configuration.
- `idx` never exceeds 9. `cnt` wraps to 0 after every bit sample.

## Configuration
- `UART_RX_MAJORITY_VOTE_EN` defined:
  - every sample (start, data, parity, stop) is the 2-of-3 majority of `rx_s` captured on the ticks at sample point −2, −1 and 0;
  - a 1-tick glitch at mid-bit is rejected.
- Undefined: every sample is the single `rx_s` value at the sample point.
- Bit timing is otherwise identical in both builds.

## Test plan
- **Reset:** hold `i_rst_n` = 0 with `i_rx` = 1 → all outputs 0 and `o_busy` = 0. After release, an 8-bit frame with parity enabled is accepted.
- **Default 8E1:** send data 0xA5 with parity bit 0 and stop bit 1 → one `o_rx_valid` pulse, `o_rx_parallel` = 9'h0A5, both errors 0. Then send 0x3C back-to-back → second pulse with 9'h03C.
- **Errors:** send 0xA5 with parity bit 1 → `o_parity_error` = 1, data = 9'h0A5. Send 0x5A with stop bit 0 → `o_frame_error` = 1.
- **Configuration:** set `i_config` = 7'b1_0_0101_1 (5 data bits, no parity, 2 stop bits). Send 5'h1F with the second stop bit 0 → data = 9'h01F and `o_frame_error` = 1. Set `i_config[4:1]` = 12 and send 9'h1FF → `o_rx_parallel` = 9'h1FF.
- **False start:** drive `i_rx` low for `OVERSAMPLE`/4 ticks → no `o_rx_valid`; `o_busy` returns to 0 before mid-bit + 1 tick.
- **Mid-frame reset and glitch:** reset pulsed at data bit 3 → no valid, IDLE next cycle. With `UART_RX_MAJORITY_VOTE_EN`, a 1-tick inverted glitch at mid-bit of data bit 2 of 0xA5 → 9'h0A5 received unchanged.
